// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the shared 256-bit block memory to icache or dcache misses.
// Define ARB_RR_EN for round-robin ties; otherwise the dcache always wins a tie.
module mem_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ic_req,
    input  logic [31:0]  ic_addr,
    output logic         ic_ack,
    output logic [255:0] ic_block,
    input  logic         dc_req,
    input  logic         dc_we,
    input  logic [31:0]  dc_raddr,
    input  logic [31:0]  dc_waddr,
    input  logic [255:0] dc_wblock,
    output logic         dc_ack,
    output logic [255:0] dc_block,
    output logic         mem_blockread,
    output logic         mem_blockwrite,
    output logic [31:0]  mem_instraddr,
    output logic [31:0]  mem_readaddr,
    output logic [31:0]  mem_writeaddr,
    output logic [255:0] mem_writeblock,
    input  logic [255:0] mem_instrblock,
    input  logic [255:0] mem_readblock,
    input  logic         mem_ready,
    output logic         busy,
    output logic         timeout_err
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

    state_t        state;
    logic          gnt_dc;
    logic          pick_dc;
    logic          start;
    logic [TW-1:0] wdog;

    assign start = (state == IDLE) && mem_ready && (ic_req || dc_req);
    assign busy  = (state != IDLE);

`ifdef ARB_RR_EN
    logic last_dc;

    // A tie goes to whichever side was not granted last.
    assign pick_dc = dc_req && !(ic_req && last_dc);

    always_ff @(posedge clk) begin
        if (reset)
            last_dc <= 1'b0;
        else if (start)
            last_dc <= pick_dc;
    end
`else
    assign pick_dc = dc_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            gnt_dc         <= 1'b0;
            wdog           <= '0;
            ic_ack         <= 1'b0;
            dc_ack         <= 1'b0;
            ic_block       <= '0;
            dc_block       <= '0;
            mem_blockread  <= 1'b0;
            mem_blockwrite <= 1'b0;
            mem_instraddr  <= '0;
            mem_readaddr   <= '0;
            mem_writeaddr  <= '0;
            mem_writeblock <= '0;
            timeout_err    <= 1'b0;
        end else begin
            ic_ack <= 1'b0;
            dc_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    wdog <= '0;
                    if (start) begin
                        state          <= ISSUE;
                        gnt_dc         <= pick_dc;
                        mem_blockread  <= 1'b1;
                        mem_blockwrite <= pick_dc && dc_we;
                        mem_instraddr  <= pick_dc ? 32'h0 : ic_addr;
                        mem_readaddr   <= pick_dc ? dc_raddr : 32'h0;
                        mem_writeaddr  <= pick_dc ? dc_waddr : 32'h0;
                        mem_writeblock <= pick_dc ? dc_wblock : '0;
                    end
                end
                ISSUE, WAIT: begin
                    wdog <= wdog + 1'b1;
                    if (wdog == TW'(TIMEOUT)) begin
                        state          <= ERR;
                        mem_blockread  <= 1'b0;
                        mem_blockwrite <= 1'b0;
                        timeout_err    <= 1'b1;
                        if (gnt_dc) begin
                            dc_ack   <= 1'b1;
                            dc_block <= '0;
                        end else begin
                            ic_ack   <= 1'b1;
                            ic_block <= '0;
                        end
                    end else if (state == ISSUE && !mem_ready) begin
                        state          <= WAIT;
                        mem_blockread  <= 1'b0;
                        mem_blockwrite <= 1'b0;
                    end else if (state == WAIT && mem_ready) begin
                        state <= DONE;
                        if (gnt_dc) begin
                            dc_ack   <= 1'b1;
                            dc_block <= mem_readblock;
                        end else begin
                            ic_ack   <= 1'b1;
                            ic_block <= mem_instrblock;
                        end
                    end
                end
                DONE, ERR: begin
                    state          <= IDLE;
                    mem_instraddr  <= '0;
                    mem_readaddr   <= '0;
                    mem_writeaddr  <= '0;
                    mem_writeblock <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
